// File: rtl/cache_fill_ctrl_pkg.sv
`default_nettype none
// =====================================================================
// cache_fill_pkg : shared types and constants for the cache fill controller
// Rev 1.0
// =====================================================================
package cache_fill_pkg;

  localparam int WORD_BYTES          = 2;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int WORD_IDX_BITS       = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int BLOCK_OFFSET_BITS   = WORD_IDX_BITS + $clog2(WORD_BYTES);

  typedef logic [WORD_IDX_BITS-1:0] word_idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_fill_ctrl_if.sv
`default_nettype none
// =====================================================================
// cache_fill_ctrl_if : miss request, memory read port and fill-array bus
// Rev 1.0
// =====================================================================
interface cache_fill_ctrl_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) ();

  logic                               miss_detected;
  logic [ADDR_WIDTH-1:0]              miss_address;
  logic                               fsm_busy;
  logic                               mem_en;
  logic                               mem_wr;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic                               mem_data_valid;
  logic [15:0]                        mem_data_out;
  logic                               fill_we;
  logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx;
  logic [15:0]                        fill_data;
  logic                               tag_we;

  modport master (
    input  miss_detected, miss_address, mem_data_valid, mem_data_out,
    output fsm_busy, mem_en, mem_wr, mem_addr, fill_we, fill_word_idx,
           fill_data, tag_we
  );

  modport slave (
    output miss_detected, miss_address, mem_data_valid, mem_data_out,
    input  fsm_busy, mem_en, mem_wr, mem_addr, fill_we, fill_word_idx,
           fill_data, tag_we
  );

endinterface
`default_nettype wire

// File: rtl/cache_fill_ctrl_fill_counter.sv
`default_nettype none
// =====================================================================
// fill_counter : mod-WORDS word counter with start-offset add and terminal flag
// Rev 1.0
// =====================================================================
module fill_counter #(
  parameter int WORDS = 8,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              clr_i,
  input  wire              inc_i,
  input  wire  [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             tc_o
);

  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  // WORDS is a power of two, so the truncating add is the modulo wrap
  assign idx_o = start_i + cnt_q;
  assign tc_o  = (cnt_q == IDX_W'(WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// =====================================================================
// cache_fill_ctrl : pipelined cache-block fill from multicycle memory
// Option macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN   Rev 1.0
// =====================================================================
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  wire               clk,
  input  wire               rst_n,
  cache_fill_ctrl_if.master bus
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = IDX_W + $clog2(WORD_BYTES);
  localparam int BLK_W = ADDR_WIDTH - OFF_W;

  fill_state_t      state_q;
  logic             busy_q;
  logic             mem_en_q;
  logic [BLK_W-1:0] blk_q;
  logic [IDX_W-1:0] start_off;
  logic [IDX_W-1:0] iss_idx;
  logic [IDX_W-1:0] ret_idx;
  logic             iss_tc;
  logic             ret_tc;
  logic             ret_fire;
  logic             ret_last;
  logic             unused_addr;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] start_q;
  assign start_off = start_q;
`else
  assign start_off = '0;
`endif

  assign ret_fire    = (state_q != S_IDLE) && bus.mem_data_valid;
  assign ret_last    = ret_fire && ret_tc;
  assign unused_addr = ^bus.miss_address[OFF_W-1:0];

  fill_counter #(.WORDS(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == S_IDLE),
    .inc_i   (state_q == S_FILL),
    .start_i (start_off),
    .idx_o   (iss_idx),
    .tc_o    (iss_tc)
  );

  fill_counter #(.WORDS(WORDS_PER_BLOCK)) u_return_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == S_IDLE),
    .inc_i   (ret_fire),
    .start_i (start_off),
    .idx_o   (ret_idx),
    .tc_o    (ret_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      mem_en_q <= 1'b0;
      blk_q    <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.miss_detected) begin
            state_q  <= S_FILL;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            blk_q    <= bus.miss_address[ADDR_WIDTH-1:OFF_W];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start_q  <= bus.miss_address[OFF_W-1:OFF_W-IDX_W];
`endif
          end
        end
        S_FILL: begin
          if (iss_tc) begin
            state_q  <= S_DRAIN;
            mem_en_q <= 1'b0;
          end
          // only reachable with a zero-latency memory; still must close cleanly
          if (ret_last) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            mem_en_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (ret_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  // A low rst_n silences every strobe in its own cycle, not just after the edge
  assign bus.fsm_busy      = rst_n & busy_q;
  assign bus.mem_en        = rst_n & mem_en_q;
  assign bus.mem_wr        = 1'b0;
  assign bus.mem_addr      = (rst_n & mem_en_q) ? {blk_q, iss_idx, {(OFF_W-IDX_W){1'b0}}}
                                                : '0;
  assign bus.fill_we       = rst_n & ret_fire;
  assign bus.fill_word_idx = (rst_n & ret_fire) ? ret_idx : '0;
  assign bus.fill_data     = bus.mem_data_out;
  assign bus.tag_we        = rst_n & ret_last;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// tb_cache_fill_ctrl : directed fills against a cycle-level block-fill model
// with a fixed-latency memory model feeding returns back.
module tb_cache_fill_ctrl;
  import cache_fill_pkg::*;

  localparam int AW   = 16;
  localparam int WPB  = 8;
  localparam int MAXC = 1024;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  localparam logic [15:0] EXP_A [0:7] = '{16'h1236, 16'h1238, 16'h123A, 16'h123C,
                                          16'h123E, 16'h1230, 16'h1232, 16'h1234};
  localparam int          EXP_I [0:7] = '{3, 4, 5, 6, 7, 0, 1, 2};
  localparam logic [15:0] EXP_SECOND  = 16'h4478;
`else
  localparam logic [15:0] EXP_A [0:7] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                                          16'h1238, 16'h123A, 16'h123C, 16'h123E};
  localparam int          EXP_I [0:7] = '{0, 1, 2, 3, 4, 5, 6, 7};
  localparam logic [15:0] EXP_SECOND  = 16'h4470;
`endif

  logic clk = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB)) bus ();

  cache_fill_ctrl #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 4;

  bit          sched_v [MAXC];
  logic [15:0] sched_d [MAXC];

  bit          m_act  = 1'b0;
  int          m_first = 0;
  int          m_nret  = 0;
  logic [15:0] m_base  = '0;
  word_idx_t   m_start = '0;

  logic [15:0] iss_log [$];
  int          iss_cyc [$];
  int          idx_log [$];
  int          we_cyc  [$];
  int          tag_cyc [$];
  int          busy_n;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare, log, memory model and reference model advance, once per cycle
  always @(negedge clk) begin : cmp
    int          k;
    int          e_idx;
    logic        e_busy, e_en, e_we, e_tag;
    logic [15:0] e_addr;

    k      = cyc - m_first;
    e_busy = m_act;
    e_en   = m_act && (k >= 0) && (k < WPB);
    e_addr = e_en ? (m_base + 16'(2 * ((int'(m_start) + k) % WPB))) : 16'h0000;
    e_we   = m_act && (bus.mem_data_valid === 1'b1);
    e_idx  = e_we ? ((int'(m_start) + m_nret) % WPB) : 0;
    e_tag  = e_we && (m_nret == WPB - 1);
    if (rst_n !== 1'b1) begin
      e_busy = 1'b0; e_en = 1'b0; e_addr = '0; e_we = 1'b0; e_idx = 0; e_tag = 1'b0;
    end

    chk("fsm_busy", 32'(bus.fsm_busy), 32'(e_busy));
    chk("mem_en", 32'(bus.mem_en), 32'(e_en));
    chk("mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("fill_we", 32'(bus.fill_we), 32'(e_we));
    chk("fill_word_idx", 32'(bus.fill_word_idx), e_idx);
    chk("tag_we", 32'(bus.tag_we), 32'(e_tag));
    chk("fill_data_pass", 32'(bus.fill_data), 32'(bus.mem_data_out));
    if (e_we) chk("fill_data_word", 32'(bus.fill_data), 32'(mem_fn(m_base + 16'(2 * e_idx))));

    if (bus.mem_en === 1'b1) begin
      iss_log.push_back(bus.mem_addr);
      iss_cyc.push_back(cyc);
      if (cyc + lat < MAXC) begin
        sched_v[cyc + lat] = 1'b1;
        sched_d[cyc + lat] = mem_fn(bus.mem_addr);
      end
    end
    if (bus.fill_we === 1'b1) begin
      idx_log.push_back(int'(bus.fill_word_idx));
      we_cyc.push_back(cyc);
    end
    if (bus.tag_we === 1'b1) tag_cyc.push_back(cyc);
    if (bus.fsm_busy === 1'b1) busy_n++;

    if (rst_n !== 1'b1) begin
      m_act = 1'b0;
    end else if (m_act) begin
      if (e_we) m_nret++;
      if (e_tag) m_act = 1'b0;
    end else if (bus.miss_detected === 1'b1) begin
      m_act   = 1'b1;
      m_first = cyc + 1;
      m_base  = bus.miss_address & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      m_start = bus.miss_address[3:1];
`else
      m_start = '0;
`endif
      m_nret  = 0;
    end
    cyc++;
  end

  task automatic drive(input logic r, input logic m, input logic [15:0] a, input logic s);
    rst_n              = r;
    bus.miss_detected  = m;
    bus.miss_address   = a;
    bus.mem_data_valid = sched_v[cyc] | s;
    bus.mem_data_out   = sched_v[cyc] ? sched_d[cyc] : 16'hBEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic clear_logs();
    iss_log.delete(); iss_cyc.delete(); idx_log.delete();
    we_cyc.delete(); tag_cyc.delete(); busy_n = 0;
  endtask

  initial begin : stim
    int e;
    // reset for two cycles, stray valid during and after reset
    clear_logs();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("reset_outputs", 32'({bus.fsm_busy, bus.mem_en, bus.mem_wr, bus.fill_we, bus.tag_we}), 32'd0);
    drive(1'b1, 1'b0, 16'h0000, 1'b1);
    idle(1);
    chk("stray_no_fill", we_cyc.size(), 0);

    // single miss, 4-cycle memory
    clear_logs();
    e = cyc;
    drive(1'b1, 1'b1, 16'h1236, 1'b0);
    idle(14);
    chk("fill1_issue_count", iss_log.size(), 8);
    for (int i = 0; i < iss_log.size() && i < 8; i++) begin
      chk("fill1_issue_addr", 32'(iss_log[i]), 32'(EXP_A[i]));
      chk("fill1_issue_cycle", iss_cyc[i] - e, i + 1);
    end
    chk("fill1_ret_count", idx_log.size(), 8);
    for (int i = 0; i < idx_log.size() && i < 8; i++) begin
      chk("fill1_word_idx", idx_log[i], EXP_I[i]);
      chk("fill1_ret_cycle", we_cyc[i] - e, i + 5);
    end
    chk("fill1_tag_count", tag_cyc.size(), 1);
    if (tag_cyc.size() > 0) chk("fill1_tag_cycle", tag_cyc[0] - e, 12);
    chk("fill1_busy_cycles", busy_n, 12);

    // miss held high, address changes mid-fill
    clear_logs();
    e = cyc;
    repeat (6) drive(1'b1, 1'b1, 16'h1236, 1'b0);
    repeat (8) drive(1'b1, 1'b1, 16'h4478, 1'b0);
    idle(16);
    chk("held_issue_count", iss_log.size(), 16);
    if (iss_log.size() > 8) begin
      chk("held_first_addr", 32'(iss_log[0]), 32'(EXP_A[0]));
      chk("held_second_addr", 32'(iss_log[8]), 32'(EXP_SECOND));
      chk("held_second_cycle", iss_cyc[8] - e, 14);
    end
    chk("held_tag_count", tag_cyc.size(), 2);
    if (tag_cyc.size() > 1) chk("held_second_tag", tag_cyc[1] - e, 25);

    // reset dropped in cycle 7 of a fill
    clear_logs();
    e = cyc;
    drive(1'b1, 1'b1, 16'h1236, 1'b0);
    idle(6);
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    idle(14);
    chk("abort_issue_count", iss_log.size(), 6);
    chk("abort_fill_count", we_cyc.size(), 2);
    chk("abort_tag_count", tag_cyc.size(), 0);
    chk("abort_idle_busy", 32'(bus.fsm_busy), 32'd0);

    // 6-cycle memory
    lat = 6;
    clear_logs();
    e = cyc;
    drive(1'b1, 1'b1, 16'h0A5C, 1'b0);
    idle(18);
    chk("lat6_fill_count", we_cyc.size(), 8);
    chk("lat6_tag_count", tag_cyc.size(), 1);
    if (tag_cyc.size() > 0 && we_cyc.size() == 8) begin
      chk("lat6_tag_with_last", tag_cyc[0], we_cyc[7]);
      chk("lat6_tag_cycle", tag_cyc[0] - e, 14);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
